// File: rtl/gear_shift_if.sv
// Gear-shift sequencer bus: selector/speed inputs toward the sequencer and
// the committed gear plus rpm_ctrl commands coming back out of it.
interface gear_shift_if;
  logic [2:0] gear_req;
  logic [3:0] req_max_level;
  logic [3:0] speed_level;
  logic       accel_in;
  logic       decel_in;
  logic [2:0] gear_out;
  logic       accel_pulse;
  logic       decel_pulse;
  logic       shifting;
  logic       shift_done;

  // Environment side: drives requests, speed and user pulses.
  modport master (
    output gear_req, req_max_level, speed_level, accel_in, decel_in,
    input  gear_out, accel_pulse, decel_pulse, shifting, shift_done
  );

  // Sequencer side.
  modport slave (
    input  gear_req, req_max_level, speed_level, accel_in, decel_in,
    output gear_out, accel_pulse, decel_pulse, shifting, shift_done
  );
endinterface

// File: rtl/gear_shift_seq.sv
// Gear-change sequencer and accel/decel command arbiter for rpm_ctrl.
// A gear request drops speed to the new gear's limit with paced decel pulses,
// holds a clutch interval, then commits the gear. User pulses pass through
// only while idle (decel wins over accel); during a speed drop user decels
// merge with the sequencer's own.
// Optional build macro GEAR_REQ_FILTER_EN: gear_req must be stable for
// STABLE_CYCLES consecutive cycles before it is acted upon.
module gear_shift_seq #(
  parameter int STEP_CYCLES   = 50,
  parameter int CLUTCH_CYCLES = 200,
  parameter int STABLE_CYCLES = 20
) (
  input  logic          clk,
  input  logic          rst,
  gear_shift_if.slave   bus
);

  // One counter width covers every interval this block can time.
  localparam int MAX_AB = (STEP_CYCLES > CLUTCH_CYCLES) ? STEP_CYCLES : CLUTCH_CYCLES;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] CLUTCH_LAST = CW'(CLUTCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DROP,
    CLUTCH,
    COMMIT
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      tgt_reg, tgt_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      gear_reg, gear_next;
  logic            accel_reg, accel_next;
  logic            decel_reg, decel_next;
  logic            shifting_reg, shifting_next;
  logic            done_reg, done_next;
  logic [2:0]      req_eff;
  logic            speed_ok;

`ifdef GEAR_REQ_FILTER_EN
  localparam logic [CW-1:0] STABLE_N = CW'(STABLE_CYCLES);

  logic [2:0]    prev_req_reg;
  logic [2:0]    filt_req_reg, filt_req_next;
  logic [CW-1:0] stab_cnt_reg, stab_cnt_next;

  // Count consecutive cycles of an unchanged request; adopt it once long enough.
  always_comb begin
    stab_cnt_next = CW'(1);
    if (bus.gear_req == prev_req_reg) begin
      stab_cnt_next = (stab_cnt_reg >= STABLE_N) ? stab_cnt_reg : stab_cnt_reg + CW'(1);
    end
    filt_req_next = filt_req_reg;
    if (stab_cnt_next >= STABLE_N) begin
      filt_req_next = bus.gear_req;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_req_reg <= '0;
      filt_req_reg <= '0;
      stab_cnt_reg <= '0;
    end else begin
      prev_req_reg <= bus.gear_req;
      filt_req_reg <= filt_req_next;
      stab_cnt_reg <= stab_cnt_next;
    end
  end

  assign req_eff = filt_req_reg;
`else
  assign req_eff = bus.gear_req;
`endif

  // Limit compare is against the live lookup for the current request.
  assign speed_ok = (bus.speed_level <= bus.req_max_level);

  // Next-state and next-output logic.
  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    cnt_next   = cnt_reg;
    gear_next  = gear_reg;
    accel_next = 1'b0;
    decel_next = 1'b0;
    done_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        decel_next = bus.decel_in;
        accel_next = bus.accel_in & ~bus.decel_in;
        if (req_eff != gear_reg) begin
          tgt_next   = req_eff;
          cnt_next   = '0;
          state_next = DROP;
        end
      end

      DROP: begin
        if (req_eff != tgt_reg) begin
          // Request moved mid-shift: back to the committed gear aborts,
          // anything else restarts the drop toward the new target.
          cnt_next = '0;
          if (req_eff == gear_reg) begin
            state_next = IDLE;
          end else begin
            tgt_next   = req_eff;
            state_next = DROP;
          end
        end else if (speed_ok) begin
          cnt_next   = '0;
          state_next = CLUTCH;
        end else begin
          // Step counter free-runs; a user decel only merges into this cycle.
          decel_next = (cnt_reg == '0) | bus.decel_in;
          cnt_next   = (cnt_reg == STEP_LAST) ? '0 : cnt_reg + CW'(1);
        end
      end

      CLUTCH: begin
        if (req_eff != tgt_reg) begin
          cnt_next = '0;
          if (req_eff == gear_reg) begin
            state_next = IDLE;
          end else begin
            tgt_next   = req_eff;
            state_next = DROP;
          end
        end else if (cnt_reg == CLUTCH_LAST) begin
          cnt_next   = '0;
          state_next = COMMIT;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      COMMIT: begin
        gear_next  = tgt_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Rises as soon as a shift is accepted and stays up through the cycle
    // in which the committed gear appears.
    shifting_next = (state_next != IDLE) || (state_reg != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      tgt_reg      <= '0;
      cnt_reg      <= '0;
      gear_reg     <= '0;
      accel_reg    <= 1'b0;
      decel_reg    <= 1'b0;
      shifting_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tgt_reg      <= tgt_next;
      cnt_reg      <= cnt_next;
      gear_reg     <= gear_next;
      accel_reg    <= accel_next;
      decel_reg    <= decel_next;
      shifting_reg <= shifting_next;
      done_reg     <= done_next;
    end
  end

  assign bus.gear_out    = gear_reg;
  assign bus.accel_pulse = accel_reg;
  assign bus.decel_pulse = decel_reg;
  assign bus.shifting    = shifting_reg;
  assign bus.shift_done  = done_reg;

endmodule
